// File: rtl/chunked_seq_adder.sv
// -----------------------------------------------------------------------------
// chunked_seq_adder
//   Multi-cycle add/subtract unit. A WIDTH-bit operation is carried out over
//   NCH = WIDTH/CHUNK clocks through a single CHUNK-bit ripple-carry stage,
//   with the inter-chunk carry held in a register.
//
// Parameters
//   WIDTH  operand/result width (positive multiple of CHUNK)
//   CHUNK  bits processed per clock
//
// Ports
//   clk    in   rising-edge clock
//   rst    in   synchronous active-high reset
//   start  in   request a new operation (sampled only while idle)
//   x, y   in   operands, captured on an accepted start
//   cin    in   carry-in (add) / borrow modifier (sub), captured on start
//   sub    in   0 = add, 1 = subtract, captured on start
//   busy   out  high while an operation is in progress
//   done   out  one-cycle pulse when s/co/ovf are valid
//   s      out  result (lower chunks fill progressively while busy)
//   co     out  carry out of bit WIDTH-1 (for subtract: 1 = no borrow)
//   ovf    out  two's-complement signed overflow
// -----------------------------------------------------------------------------
module chunked_seq_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf
);

  localparam int NCH = WIDTH / CHUNK;
  // Keep the chunk index at least one bit wide so CHUNK == WIDTH still works.
  localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NCH - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;       // already inverted when subtracting
  logic             carry_q, carry_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             co_q, co_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  logic             accept;
  logic [CHUNK-1:0] a_ch [NCH];
  logic [CHUNK-1:0] b_ch [NCH];
  logic [CHUNK-1:0] a_cur, b_cur;
  logic [CHUNK-1:0] sum_ch;
  logic [CHUNK:0]   rc;

  assign accept = (state_q == IDLE) && start;

  // Split the captured operands into chunks; the chunk index picks one.
  for (genvar gi = 0; gi < NCH; gi++) begin : g_slice
    assign a_ch[gi] = a_q[gi*CHUNK +: CHUNK];
    assign b_ch[gi] = b_q[gi*CHUNK +: CHUNK];
  end

  assign a_cur = a_ch[k_q];
  assign b_cur = b_ch[k_q];

  // The single CHUNK-bit ripple-carry stage shared by all chunk cycles.
  assign rc[0] = carry_q;
  for (genvar gi = 0; gi < CHUNK; gi++) begin : g_ripple
    assign sum_ch[gi] = a_cur[gi] ^ b_cur[gi] ^ rc[gi];
    assign rc[gi+1]   = (a_cur[gi] & b_cur[gi]) | (rc[gi] & (a_cur[gi] ^ b_cur[gi]));
  end

  // Result chunks: cleared on acceptance, written when their turn comes,
  // otherwise held.
  for (genvar gi = 0; gi < NCH; gi++) begin : g_result
    assign s_d[gi*CHUNK +: CHUNK] =
      accept                                   ? '0     :
      ((state_q == RUN) && (k_q == KW'(gi)))   ? sum_ch :
                                                 s_q[gi*CHUNK +: CHUNK];
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    k_d     = k_q;
    co_d    = co_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          // Subtraction is x + ~y + 1; cin flips that final +1 into a borrow.
          a_d     = x;
          b_d     = y ^ {WIDTH{sub}};
          carry_d = cin ^ sub;
          k_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        carry_d = rc[CHUNK];
        k_d     = k_q + 1'b1;
        if (k_q == K_LAST) begin
          // sum_ch[CHUNK-1] is the result MSB on the final chunk.
          state_d = IDLE;
          k_d     = '0;
          co_d    = rc[CHUNK];
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_ch[CHUNK-1] != a_q[WIDTH-1]);
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      k_q     <= '0;
      s_q     <= '0;
      co_q    <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      k_q     <= k_d;
      s_q     <= s_d;
      co_q    <= co_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = done_q;
  assign s    = s_q;
  assign co   = co_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_chunked_seq_adder.sv
module tb_chunked_seq_adder;

  logic        clk = 1'b0;
  logic        rst, start, cin, sub;
  logic [15:0] x, y;
  logic        busy, done, co, ovf;
  logic [15:0] s;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [15:0] s;
    logic        co;
    logic        ovf;
  } exp_t;

  exp_t sb[$];

  chunked_seq_adder #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst(rst), .start(start), .x(x), .y(y), .cin(cin), .sub(sub),
    .busy(busy), .done(done), .s(s), .co(co), .ovf(ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  // Reference: unsigned 17-bit sum for s/co, signed range test for ovf.
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                 input logic ci, input logic sb_i);
    exp_t        e;
    logic [15:0] bp;
    logic        c;
    logic [16:0] full;
    int          sv;
    bp    = sb_i ? ~b : b;
    c     = ci ^ sb_i;
    full  = {1'b0, a} + {1'b0, bp} + {16'd0, c};
    sv    = int'($signed(a)) + int'($signed(bp)) + (c ? 1 : 0);
    e.s   = full[15:0];
    e.co  = full[16];
    e.ovf = (sv > 32767) || (sv < -32768);
    return e;
  endfunction

  // One complete operation: drive, push expectation, wait for done, compare.
  task automatic run_op(input string name, input logic [15:0] xv, input logic [15:0] yv,
                        input logic ci, input logic sb_i);
    int   n;
    int   busy_cnt;
    exp_t e;
    @(negedge clk);
    x = xv; y = yv; cin = ci; sub = sb_i; start = 1'b1;
    sb.push_back(model(xv, yv, ci, sb_i));
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || s !== 16'h0000) begin
      errors++;
      $display("FAIL %s_accept: busy=%b s=%h, expected busy=1 s=0000", name, busy, s);
    end
    n = 0; busy_cnt = 0;
    while (done !== 1'b1 && n < 20) begin
      if (busy === 1'b1) busy_cnt++;
      @(negedge clk);
      n++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL %s_timeout: done not seen, expected done within 20 cycles", name);
      sb.delete();
      return;
    end
    e = sb.pop_front();
    if ({s, co, ovf} !== e) begin
      errors++;
      $display("FAIL %s_result: s=%h co=%b ovf=%b, expected s=%h co=%b ovf=%b",
               name, s, co, ovf, e.s, e.co, e.ovf);
    end
    $display("op %s: x=%h y=%h cin=%b sub=%b -> s=%h co=%b ovf=%b", name, xv, yv, ci, sb_i, s, co, ovf);
    checks++;
    if (busy_cnt != 4 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_busy: busy cycles=%0d busy_at_done=%b, expected 4 and 0", name, busy_cnt, busy);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL %s_pulse: done=%b one cycle later, expected 0", name, done);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; x = 16'h0; y = 16'h0; cin = 1'b0; sub = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || s !== 16'h0 || co !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b s=%h co=%b ovf=%b, expected all 0", busy, done, s, co, ovf);
    end
    rst = 1'b0;
  endtask

  task automatic test_add();
    run_op("add_basic", 16'h1234, 16'h4321, 1'b0, 1'b0);
    run_op("add_ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0);
    run_op("add_cin", 16'hFFFF, 16'h0000, 1'b1, 1'b0);
  endtask

  task automatic test_sub();
    run_op("sub_neg", 16'h0005, 16'h0007, 1'b0, 1'b1);
    run_op("sub_borrow", 16'h0005, 16'h0007, 1'b1, 1'b1);
    run_op("sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1);
  endtask

  task automatic test_overflow();
    run_op("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [15:0] tx [4] = '{16'h7FFF, 16'hA5A5, 16'h0100, 16'hFFFF};
    logic [15:0] ty [4] = '{16'h0001, 16'h5A5A, 16'h0200, 16'hFFFF};
    logic        tc [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic        ts [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    int   pushed = 0;
    int   popped = 0;
    int   n = 0;
    exp_t e;
    @(negedge clk);
    start = 1'b1;
    while (popped < 4 && n < 100) begin
      if (done === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL b2b_extra_done: done with empty scoreboard, expected none");
        end else begin
          e = sb.pop_front();
          if ({s, co, ovf} !== e) begin
            errors++;
            $display("FAIL b2b_result%0d: s=%h co=%b ovf=%b, expected s=%h co=%b ovf=%b",
                     popped, s, co, ovf, e.s, e.co, e.ovf);
          end
          $display("op b2b%0d: s=%h co=%b ovf=%b", popped, s, co, ovf);
        end
        popped++;
      end
      if (busy === 1'b0) begin
        if (pushed < 4) begin
          x = tx[pushed]; y = ty[pushed]; cin = tc[pushed]; sub = ts[pushed];
          sb.push_back(model(tx[pushed], ty[pushed], tc[pushed], ts[pushed]));
          pushed++;
        end else begin
          start = 1'b0;
        end
      end else begin
        // Operand changes while busy must not disturb the captured values.
        x = 16'($urandom); y = 16'($urandom);
        cin = 1'($urandom); sub = 1'($urandom);
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    checks++;
    if (popped != 4) begin
      errors++;
      $display("FAIL b2b_count: results=%0d, expected 4", popped);
      sb.delete();
    end
  endtask

  task automatic test_start_ignored();
    int   dones = 0;
    exp_t e;
    @(negedge clk);
    x = 16'h1111; y = 16'h2222; cin = 1'b0; sub = 1'b0; start = 1'b1;
    sb.push_back(model(16'h1111, 16'h2222, 1'b0, 1'b0));
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    x = 16'h9999; y = 16'h0F0F; sub = 1'b1; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (done === 1'b1) begin
        dones++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL ignore_extra_done: done with empty scoreboard, expected none");
        end else begin
          e = sb.pop_front();
          if ({s, co, ovf} !== e) begin
            errors++;
            $display("FAIL ignore_result: s=%h co=%b ovf=%b, expected s=%h co=%b ovf=%b",
                     s, co, ovf, e.s, e.co, e.ovf);
          end
          $display("op ignore: s=%h co=%b ovf=%b", s, co, ovf);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (dones != 1) begin
      errors++;
      $display("FAIL ignore_done_count: done pulses=%0d, expected 1", dones);
    end
    sb.delete();
  endtask

  task automatic test_reset_mid();
    int dones = 0;
    run_op("pre_rst", 16'h8000, 16'h0001, 1'b0, 1'b1);
    @(negedge clk);
    x = 16'hFFFF; y = 16'h7FFF; cin = 1'b1; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || s !== 16'h0 || co !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: busy=%b done=%b s=%h co=%b ovf=%b, expected all 0", busy, done, s, co, ovf);
    end
    for (int i = 0; i < 8; i++) begin
      if (done === 1'b1) dones++;
      @(negedge clk);
    end
    checks++;
    if (dones != 0) begin
      errors++;
      $display("FAIL mid_reset_done: done pulses=%0d, expected 0", dones);
    end
    run_op("post_rst", 16'h0F0F, 16'h00F1, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_overflow();
    test_back_to_back();
    test_start_ignored();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
